// File: rtl/apb_master_if.sv
// APB bus bundle between one master and NUM_SLV slaves.
// Slave i owns PSEL[i], PREADY[i] and PRDATA[32i+31:32i].
interface apb_master_if #(
  parameter int unsigned NUM_SLV = 4
);
  logic [31:0]           PADDR;
  logic [31:0]           PWDATA;
  logic                  PWRITE;
  logic [NUM_SLV-1:0]    PSEL;
  logic                  PENABLE;
  logic [32*NUM_SLV-1:0] PRDATA;
  logic [NUM_SLV-1:0]    PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_master.sv
// APB master bridging single-cycle CPU requests onto NUM_SLV 4 KB slave windows,
// with decode-miss and PREADY-timeout error completion.
module apb_master #(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic         transfer,
  input  logic         write,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         ready,
  output logic         err,
  output logic         busy,
  apb_master_if.master bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;

  logic [IW-1:0]      idx_c;
  logic               hit_c;
  logic [NUM_SLV-1:0] dec_c;
  logic               pready_c;
  logic [DW-1:0]      prdata_c;

  // Address decode of the incoming request
  always_comb begin
    idx_c = addr[14:12];
    hit_c = (addr[31:15] == BASE_ADDR[31:15]) && (32'(idx_c) < NUM_SLV);
    dec_c = NUM_SLV'(1) << idx_c;
  end

  // Only the selected slave's ready/data are visible; PSEL is one-hot
  always_comb begin
    pready_c = 1'b0;
    prdata_c = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (bus.PSEL[i]) begin
        pready_c = pready_c | bus.PREADY[i];
        prdata_c = prdata_c | bus.PRDATA[DW*i +: DW];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      bus.PADDR   <= '0;
      bus.PWDATA  <= '0;
      bus.PWRITE  <= 1'b0;
      bus.PSEL    <= '0;
      bus.PENABLE <= 1'b0;
      rdata       <= '0;
      ready       <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            if (hit_c) begin
              state       <= SETUP;
              busy        <= 1'b1;
              wait_cnt    <= '0;
              bus.PADDR   <= addr;
              bus.PWDATA  <= wdata;
              bus.PWRITE  <= write;
              bus.PSEL    <= dec_c;
              bus.PENABLE <= 1'b0;
            end else begin
              // Decode miss completes immediately without touching the bus
              ready <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (pready_c) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            ready       <= 1'b1;
            rdata       <= bus.PWRITE ? '0 : prdata_c;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            ready       <= 1'b1;
            err         <= 1'b1;
            rdata       <= '0;
            wait_cnt    <= wait_cnt + CW'(1);
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          bus.PSEL    <= '0;
          bus.PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: zero-wait write, wait-state read, decode miss,
// timeout, busy/back-to-back and mid-transfer reset.
module tb_apb_master;

  localparam int unsigned NUM_SLV = 4;

  logic        PCLK;
  logic        PRESET;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  int n_tests;
  int n_fail;

  apb_master_if #(.NUM_SLV(NUM_SLV)) apb ();

  apb_master #(
    .NUM_SLV  (NUM_SLV),
    .BASE_ADDR(32'h1000_0000),
    .TIMEOUT  (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .busy    (busy),
    .bus     (apb)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
    transfer = 1'b1;
    write    = w;
    addr     = a;
    wdata    = d;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    PRESET     = 1'b1;
    transfer   = 1'b0;
    write      = 1'b0;
    addr       = '0;
    wdata      = '0;
    apb.PREADY = '1;
    apb.PRDATA = {32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

    // Reset state
    tick();
    tick();
    PRESET = 1'b0;
    chk("rst_psel",    32'(apb.PSEL),    32'h0);
    chk("rst_penable", 32'(apb.PENABLE), 32'h0);
    chk("rst_paddr",   apb.PADDR,        32'h0);
    chk("rst_pwdata",  apb.PWDATA,       32'h0);
    chk("rst_rdata",   rdata,            32'h0);
    chk("rst_ready",   32'(ready),       32'h0);
    chk("rst_busy",    32'(busy),        32'h0);

    // Zero-wait write to slave 1
    req(1'b1, 32'h1000_1004, 32'h0000_00A5);
    tick();
    transfer = 1'b0;
    chk("w0_setup_psel",    32'(apb.PSEL),    32'h2);
    chk("w0_setup_penable", 32'(apb.PENABLE), 32'h0);
    chk("w0_setup_paddr",   apb.PADDR,        32'h1000_1004);
    chk("w0_setup_pwdata",  apb.PWDATA,       32'h0000_00A5);
    chk("w0_setup_pwrite",  32'(apb.PWRITE),  32'h1);
    chk("w0_setup_busy",    32'(busy),        32'h1);
    tick();
    chk("w0_access_penable", 32'(apb.PENABLE), 32'h1);
    chk("w0_access_psel",    32'(apb.PSEL),    32'h2);
    chk("w0_access_ready",   32'(ready),       32'h0);
    tick();
    chk("w0_done_ready",   32'(ready),       32'h1);
    chk("w0_done_err",     32'(err),         32'h0);
    chk("w0_done_rdata",   rdata,            32'h0);
    chk("w0_done_psel",    32'(apb.PSEL),    32'h0);
    chk("w0_done_penable", 32'(apb.PENABLE), 32'h0);
    chk("w0_done_busy",    32'(busy),        32'h0);
    tick();
    chk("w0_after_ready", 32'(ready), 32'h0);
    chk("w0_idle_paddr",  apb.PADDR,  32'h1000_1004);

    // Read slave 3 with 3 wait states; PREADY lands on the 4th ACCESS cycle (TIMEOUT=4)
    apb.PREADY = 4'b0111;
    req(1'b0, 32'h1000_3010, 32'h0);
    tick();
    transfer = 1'b0;
    chk("r3_setup_psel", 32'(apb.PSEL), 32'h8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r3_wait_penable", 32'(apb.PENABLE), 32'h1);
      chk("r3_wait_psel",    32'(apb.PSEL),    32'h8);
      chk("r3_wait_paddr",   apb.PADDR,        32'h1000_3010);
      chk("r3_wait_pwrite",  32'(apb.PWRITE),  32'h0);
      chk("r3_wait_ready",   32'(ready),       32'h0);
      if (i == 3) apb.PREADY = 4'b1111;
    end
    tick();
    apb.PREADY = 4'b0111;
    chk("r3_done_ready", 32'(ready), 32'h1);
    chk("r3_done_err",   32'(err),   32'h0);
    chk("r3_done_rdata", rdata,      32'hDEAD_BEEF);
    tick();
    chk("r3_after_ready", 32'(ready), 32'h0);
    chk("r3_rdata_hold",  rdata,      32'hDEAD_BEEF);

    // Decode misses: outside window, then index beyond NUM_SLV
    req(1'b0, 32'h2000_0000, 32'h0);
    tick();
    transfer = 1'b0;
    chk("miss0_ready", 32'(ready),    32'h1);
    chk("miss0_err",   32'(err),      32'h1);
    chk("miss0_rdata", rdata,         32'h0);
    chk("miss0_psel",  32'(apb.PSEL), 32'h0);
    chk("miss0_busy",  32'(busy),     32'h0);
    tick();
    chk("miss0_after_ready", 32'(ready), 32'h0);
    req(1'b0, 32'h1000_4000, 32'h0);
    tick();
    transfer = 1'b0;
    chk("miss1_ready", 32'(ready),    32'h1);
    chk("miss1_err",   32'(err),      32'h1);
    chk("miss1_psel",  32'(apb.PSEL), 32'h0);
    tick();
    chk("miss1_after_ready", 32'(ready), 32'h0);
    chk("miss1_after_err",   32'(err),   32'h0);

    // Timeout on slave 0 that never answers
    apb.PREADY = 4'b0000;
    req(1'b1, 32'h1000_0008, 32'h5555_AAAA);
    tick();
    transfer = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_wait_penable", 32'(apb.PENABLE), 32'h1);
      chk("to_wait_ready",   32'(ready),       32'h0);
    end
    tick();
    chk("to_ready",   32'(ready),       32'h1);
    chk("to_err",     32'(err),         32'h1);
    chk("to_psel",    32'(apb.PSEL),    32'h0);
    chk("to_penable", 32'(apb.PENABLE), 32'h0);
    chk("to_rdata",   rdata,            32'h0);
    apb.PREADY = 4'b1111;
    req(1'b0, 32'h1000_2000, 32'h0);
    tick();
    transfer = 1'b0;
    chk("to_next_psel", 32'(apb.PSEL), 32'h4);
    tick();
    tick();
    chk("to_next_ready", 32'(ready), 32'h1);
    chk("to_next_err",   32'(err),   32'h0);
    chk("to_next_rdata", rdata,      32'h2222_2222);

    // Transfer during SETUP is dropped
    tick();
    req(1'b1, 32'h1000_0000, 32'h1);
    tick();
    req(1'b1, 32'h1000_1000, 32'h2);
    tick();
    transfer = 1'b0;
    chk("busy_psel_kept", 32'(apb.PSEL), 32'h1);
    tick();
    chk("busy_ready", 32'(ready), 32'h1);
    tick();
    chk("busy_no_2nd_ready", 32'(ready), 32'h0);
    chk("busy_no_2nd_busy",  32'(busy),  32'h0);
    tick();
    chk("busy_no_2nd_psel", 32'(apb.PSEL), 32'h0);

    // Back-to-back: new transfer coincident with ready
    req(1'b0, 32'h1000_1000, 32'h0);
    tick();
    transfer = 1'b0;
    tick();
    tick();
    chk("b2b_first_ready", 32'(ready), 32'h1);
    req(1'b0, 32'h1000_3000, 32'h0);
    tick();
    transfer = 1'b0;
    chk("b2b_setup_psel",  32'(apb.PSEL), 32'h8);
    chk("b2b_setup_busy",  32'(busy),     32'h1);
    chk("b2b_setup_ready", 32'(ready),    32'h0);
    tick();
    tick();
    chk("b2b_second_ready", 32'(ready), 32'h1);
    chk("b2b_second_rdata", rdata,      32'hDEAD_BEEF);
    tick();

    // Reset mid-ACCESS with a concurrent transfer
    apb.PREADY = 4'b0000;
    req(1'b1, 32'h1000_2004, 32'h7777_0000);
    tick();
    transfer = 1'b0;
    tick();
    chk("mrst_pre_penable", 32'(apb.PENABLE), 32'h1);
    PRESET = 1'b1;
    req(1'b1, 32'h1000_1000, 32'h1);
    tick();
    PRESET   = 1'b0;
    transfer = 1'b0;
    chk("mrst_psel",    32'(apb.PSEL),    32'h0);
    chk("mrst_penable", 32'(apb.PENABLE), 32'h0);
    chk("mrst_paddr",   apb.PADDR,        32'h0);
    chk("mrst_ready",   32'(ready),       32'h0);
    chk("mrst_busy",    32'(busy),        32'h0);
    chk("mrst_rdata",   rdata,            32'h0);
    tick();
    chk("mrst_after_ready", 32'(ready),    32'h0);
    chk("mrst_after_psel",  32'(apb.PSEL), 32'h0);
    chk("mrst_after_busy",  32'(busy),     32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter NUM_SLV, default 4 (1..8), the number of APB slaves decoded.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h1000_0000, the start of the peripheral window, with 4 KB per slave.
REQ-003 The block SHALL have parameter TIMEOUT, default 255 (1..255), the maximum number of ACCESS cycles to wait for PREADY.
REQ-004 The block SHALL have port PCLK  in  1  system clock (single clock).
REQ-005 The block SHALL have port PRESET  in  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port transfer  in  1  single-cycle request pulse from the CPU side.
REQ-007 The block SHALL have port write  in  1  request direction, 1=write.
REQ-008 The block SHALL have port addr  in  32  request byte address.
REQ-009 The block SHALL have port wdata  in  32  request write data.
REQ-010 The block SHALL have port rdata  out  32  read data, valid while ready=1.
REQ-011 The block SHALL have port ready  out  1  one-cycle completion pulse.
REQ-012 The block SHALL have port err  out  1  error flag, qualified by ready (decode miss or timeout).
REQ-013 The block SHALL have port busy  out  1  high when the state is not IDLE.
REQ-014 The block SHALL have ports PADDR  out  32, PWDATA  out  32 and PWRITE  out  1  APB address, data and direction.
REQ-015 The block SHALL have ports PSEL  out  NUM_SLV and PENABLE  out  1  one-hot slave select and enable.
REQ-016 The block SHALL have ports PRDATA  in  32*NUM_SLV and PREADY  in  NUM_SLV  per-slave read data (slave i at bits [32i+31:32i]) and ready.

Function
REQ-017 The block SHALL use the states IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-018 In IDLE with transfer=1, the block SHALL latch addr, wdata and write, and SHALL decode slave index = addr[14:12]; the address hits only if addr[31:15]==BASE_ADDR[31:15] and index<NUM_SLV.
REQ-019 On a hit, the next state SHALL be SETUP: PSEL[index]=1, PENABLE=0, PADDR/PWDATA/PWRITE = latched values.
REQ-020 On a miss, the block SHALL run no APB cycle: it SHALL stay in IDLE, pulse ready=1 and err=1 in the next cycle, and drive rdata=0.
REQ-021 SETUP SHALL always advance to ACCESS after exactly one cycle, with PENABLE=1 and PSEL held.
REQ-022 In ACCESS, the block SHALL sample only PREADY[index] and PRDATA[index]; all other slaves' inputs SHALL be ignored.
REQ-023 When PREADY[index]=1 in ACCESS, the block SHALL go to IDLE; in the next cycle PSEL=0, PENABLE=0, ready=1, err=0, and rdata = sampled PRDATA (0 for writes).
REQ-024 While in ACCESS with PREADY=0, the block SHALL increment a wait counter (cleared on entry to SETUP); PADDR, PWDATA, PWRITE, PSEL and PENABLE SHALL stay stable.
REQ-025 When the counter reaches TIMEOUT with PREADY still 0, the block SHALL abort to IDLE; in the next cycle PSEL=0, PENABLE=0, ready=1, err=1, rdata=0.
REQ-026 If PREADY arrives in the same cycle the counter reaches TIMEOUT, the transfer SHALL complete normally (err=0).
REQ-027 ready and err SHALL be high for exactly one cycle per accepted request and low otherwise; rdata SHALL hold its value until the next completion.
REQ-028 transfer SHALL be ignored when busy=1: it is not queued and produces no ready.
REQ-029 A transfer in the same cycle as a ready pulse (state IDLE) SHALL be accepted, giving back-to-back transfers 3 cycles apart at zero wait.
REQ-030 PADDR, PWDATA and PWRITE SHALL keep their last values in IDLE; PSEL SHALL be 0 in IDLE.
REQ-031 Zero-wait latency SHALL be: transfer at edge k, SETUP at cycle k+1, ACCESS at cycle k+2, ready at cycle k+3.

Reset
REQ-032 While PRESET=1 at a PCLK edge, the block SHALL go to IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, ready=0, err=0, busy=0, and the wait counter SHALL be 0.
REQ-033 A reset asserted mid-transfer SHALL drop PSEL/PENABLE at that edge without producing a ready pulse; transfer during reset SHALL be ignored.

Verification
REQ-034 The bench SHALL cover a zero-wait write: transfer, write=1, addr=32'h1000_1004, wdata=32'hA5 -> PSEL=4'b0010, PADDR=32'h1000_1004, PWDATA=32'hA5, one SETUP cycle then one ACCESS cycle; ready=1, err=0 at k+3.
REQ-035 The bench SHALL cover a read with 3 wait states: slave 3 holds PREADY low for 3 cycles and PRDATA3=32'hDEAD_BEEF -> PENABLE high for 4 cycles, signals stable, rdata=32'hDEAD_BEEF, ready at k+6.
REQ-036 The bench SHALL cover a decode miss: addr=32'h2000_0000 (and 32'h1000_4000 with NUM_SLV=4) -> PSEL stays 0, ready=1, err=1 and rdata=0 the next cycle.
REQ-037 The bench SHALL cover a timeout: TIMEOUT=4, slave never ready -> abort after 4 ACCESS cycles, ready=1, err=1; a following transfer completes normally.
REQ-038 The bench SHALL cover busy/back-to-back: a transfer during SETUP is ignored (exactly one ready); a transfer coincident with ready starts SETUP on the next cycle.
REQ-039 The bench SHALL cover a reset mid-ACCESS: PRESET=1 for one cycle -> all outputs 0 at that edge, no ready pulse, busy=0.
